sha_ctrl: RTL and testbench

- Message controller that sequences sha_block for one message at a time.
- Accepts a byte stream over a valid/ready handshake and assembles Nd-byte blocks.
- Applies standard SHA padding: 0x80 terminator, zero fill, big-endian bit length.
- Presents each block to sha_block with Enable/Function, then waits for completion before building the next block.

---
 rtl/sha_ctrl_pkg.sv | 54 +++++
 rtl/sha_ctrl_if.sv | 30 +++
 rtl/sha_ctrl.sv | 115 +++++++++++
 tb/tb_sha_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/sha_ctrl_pkg.sv
// sha_ctrl_pkg: shared constants and types for the SHA message controller.
//   Nd  - block size in bytes
//   Nl  - length-field size in bytes
//   Lw  - message bit-length counter width (Lw <= 8*Nl)
//   state_t  - controller states
//   reg_t    - complete controller register record, REG_INIT its reset value
//   len_field - big-endian bit-length field built from the byte count
package sha_ctrl_pkg;

  localparam int Nd = 64;
  localparam int Nl = 8;
  localparam int Lw = 64;

  localparam int PW = $clog2(Nd + 1);  // pointer must be able to hold Nd
  localparam int IW = $clog2(Nd);      // byte index inside a block
  localparam int CW = Lw - 3;          // byte count; bit count = count * 8

  typedef enum logic [2:0] {
    IDLE, FILL, PAD, ZERO, LEN, ISSUE, WAIT
  } state_t;

  typedef struct packed {
    state_t               st;
    state_t               ret;    // where to resume after a non-final block
    logic [PW-1:0]        ptr;
    logic [CW-1:0]        cnt;
    logic                 first;
    logic                 fin;    // block being issued is the last one
    logic                 busy;
    logic                 done;
    logic [Nd-1:0][7:0]   data;   // data[0] is the first byte of the block
  } reg_t;

  localparam reg_t REG_INIT = '{
    st:    IDLE,
    ret:   IDLE,
    ptr:   '0,
    cnt:   '0,
    first: 1'b1,
    fin:   1'b0,
    busy:  1'b0,
    done:  1'b0,
    data:  '0
  };

  // Byte count times eight, zero-extended to the full length field.
  function automatic logic [8*Nl-1:0] len_field(input logic [CW-1:0] cnt);
    logic [8*Nl-1:0] f;
    f         = '0;
    f[Lw-1:0] = {cnt, 3'b000};
    return f;
  endfunction

endpackage

// File: rtl/sha_ctrl_if.sv
// sha_ctrl_if: byte-stream input and sha_block-facing signals of sha_ctrl.
//   In_Data/In_Valid/In_Last/In_Ready - message byte handshake
//   Block_Data/Block_Enable/Block_Function/Block_Ready - sha_block control
//   Busy/Msg_Done - message status
// Modports: slave = the controller, master = its environment.
interface sha_ctrl_if;
  import sha_ctrl_pkg::*;

  logic [7:0]         In_Data;
  logic               In_Valid;
  logic               In_Last;
  logic               In_Ready;
  logic [Nd-1:0][7:0] Block_Data;
  logic               Block_Enable;
  logic               Block_Function;
  logic               Block_Ready;
  logic               Busy;
  logic               Msg_Done;

  modport slave (
    input  In_Data, In_Valid, In_Last, Block_Ready,
    output In_Ready, Block_Data, Block_Enable, Block_Function, Busy, Msg_Done
  );

  modport master (
    output In_Data, In_Valid, In_Last, Block_Ready,
    input  In_Ready, Block_Data, Block_Enable, Block_Function, Busy, Msg_Done
  );

endinterface

// File: rtl/sha_ctrl.sv
// sha_ctrl: assembles a byte stream into Nd-byte blocks, applies SHA padding
// (0x80, zero fill, big-endian bit length) and hands each block to sha_block,
// waiting for its Ready pulse before building the next one.
//   clk  - clock, rising edge
//   rst  - asynchronous, active-low reset
//   bus  - sha_ctrl_if.slave: byte input, block output and status
module sha_ctrl
  import sha_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  sha_ctrl_if.slave   bus
);

  reg_t              r, v;
  logic              rdy;
  logic              acc;
  logic [PW-1:0]     p1;
  logic [IW-1:0]     idx;
  logic [8*Nl-1:0]   lf;

  assign rdy = (r.st == IDLE) || ((r.st == FILL) && (r.ptr < PW'(Nd)));

  // In_Ready is gated by rst so it reads 0 while reset is held, even though
  // the idle state itself advertises readiness.
  assign bus.In_Ready       = rst & rdy;
  assign bus.Block_Data     = r.data;
  assign bus.Block_Enable   = (r.st == ISSUE);
  assign bus.Block_Function = (r.st == ISSUE) & ~r.first;
  assign bus.Busy           = r.busy;
  assign bus.Msg_Done       = r.done;

  always_comb begin
    v      = r;
    v.done = 1'b0;
    acc    = bus.In_Valid & rdy;
    p1     = r.ptr + PW'(1);
    idx    = r.ptr[IW-1:0];
    lf     = len_field(r.cnt);

    unique case (r.st)
      IDLE, FILL: begin
        if (acc) begin
          v.data[idx] = bus.In_Data;
          v.ptr       = p1;
          v.cnt       = r.cnt + CW'(1);
          v.fin       = 1'b0;
          if (r.st == IDLE) begin
            v.first = 1'b1;
            v.busy  = 1'b1;
          end
          // A last byte that also fills the block issues it first and
          // starts padding in a fresh block.
          if (p1 == PW'(Nd)) begin
            v.st  = ISSUE;
            v.ret = bus.In_Last ? PAD : FILL;
          end else begin
            v.st = bus.In_Last ? PAD : FILL;
          end
        end
      end

      PAD, ZERO: begin
        v.data[idx] = (r.st == PAD) ? 8'h80 : 8'h00;
        v.ptr       = p1;
        // Stop at the length field if it still fits, otherwise spill the
        // zero fill into another block.
        if (p1 == PW'(Nd - Nl)) begin
          v.st = LEN;
        end else if (p1 == PW'(Nd)) begin
          v.st  = ISSUE;
          v.ret = ZERO;
          v.fin = 1'b0;
        end else begin
          v.st = ZERO;
        end
      end

      LEN: begin
        for (int i = 0; i < Nl; i++) begin
          v.data[Nd-1-i] = lf[8*i +: 8];
        end
        v.fin = 1'b1;
        v.st  = ISSUE;
      end

      ISSUE: begin
        v.first = 1'b0;
        v.st    = WAIT;
      end

      WAIT: begin
        if (bus.Block_Ready) begin
          v.ptr = '0;
          if (r.fin) begin
            v.st   = IDLE;
            v.done = 1'b1;
            v.busy = 1'b0;
            v.cnt  = '0;
          end else begin
            v.st = r.ret;
          end
        end
      end

      default: v = REG_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r <= REG_INIT;
    else      r <= v;
  end

endmodule

// File: tb/tb_sha_ctrl.sv
// tb_sha_ctrl: randomized bench for sha_ctrl. A reference model pads each
// message arithmetically into a flat byte array; a responder compares every
// issued block, Function flag and completion pulse against it.
module tb_sha_ctrl;
  import sha_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  sha_ctrl_if bif ();

  sha_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Padded message: bytes, 0x80, zeros until the length field lands at the
  // end of a block, then the bit length big-endian.
  function automatic void model(input logic [7:0] m[$], output logic [7:0] e[$]);
    longint unsigned bits;
    bits = longint'(m.size()) * 8;
    e = m;
    e.push_back(8'h80);
    while ((e.size() % Nd) != (Nd - Nl)) e.push_back(8'h00);
    for (int i = Nl - 1; i >= 0; i--)
      e.push_back((i < 8) ? 8'(bits >> (8 * i)) : 8'h00);
  endfunction

  task automatic drive(input logic [7:0] m[$], input bit gaps);
    int i = 0;
    int guard = 0;
    while (i < m.size()) begin
      @(negedge clk);
      guard++;
      if (guard > 5000) begin
        chk("drive_timeout", 64'(1), 64'(0));
        break;
      end
      if (gaps && ($urandom_range(0, 3) == 0)) begin
        bif.In_Valid = 1'b0;
        bif.In_Data  = 8'($urandom);
        bif.In_Last  = 1'($urandom);
      end else begin
        bif.In_Valid = 1'b1;
        bif.In_Data  = m[i];
        bif.In_Last  = (i == m.size() - 1);
        if (bif.In_Ready) i++;
      end
    end
    @(negedge clk);
    bif.In_Valid = 1'b0;
    bif.In_Last  = 1'b0;
  endtask

  task automatic respond(input logic [7:0] e[$], input bit abort);
    int nblk = e.size() / Nd;
    int k = 0;
    int guard = 0;
    bit fin = 1'b0;
    logic [Nd-1:0][7:0] snap;
    while (!fin) begin
      @(negedge clk);
      guard++;
      if (guard > 6000) begin
        chk("respond_timeout", 64'(1), 64'(0));
        break;
      end
      if (bif.Block_Enable) begin
        chk($sformatf("func%0d", k), 64'(bif.Block_Function), 64'(k != 0));
        chk($sformatf("busy%0d", k), 64'(bif.Busy), 64'(1));
        for (int b = 0; b < Nd; b++)
          chk($sformatf("blk%0d[%0d]", k, b), 64'(bif.Block_Data[b]), 64'(e[k*Nd + b]));
        snap = bif.Block_Data;
        k++;
        if (abort) begin
          #2 rst = 1'b0;
          #1;
          chk("rst_enable", 64'(bif.Block_Enable), 64'(0));
          chk("rst_func",   64'(bif.Block_Function), 64'(0));
          chk("rst_ready",  64'(bif.In_Ready), 64'(0));
          chk("rst_busy",   64'(bif.Busy), 64'(0));
          chk("rst_done",   64'(bif.Msg_Done), 64'(0));
          chk("rst_data",   64'(bif.Block_Data == '0), 64'(1));
          @(negedge clk);
          rst = 1'b1;
          #1;
          chk("rst_idle_ready", 64'(bif.In_Ready), 64'(1));
          fin = 1'b1;
        end else begin
          repeat ($urandom_range(1, 4)) begin
            @(negedge clk);
            chk("enable_pulse", 64'(bif.Block_Enable), 64'(0));
            chk("wait_ready",   64'(bif.In_Ready), 64'(0));
            chk("wait_hold",    64'(bif.Block_Data == snap), 64'(1));
          end
          bif.Block_Ready = 1'b1;
          @(negedge clk);
          bif.Block_Ready = 1'b0;
          if (k == nblk) begin
            chk("msg_done", 64'(bif.Msg_Done), 64'(1));
            chk("busy_end", 64'(bif.Busy), 64'(0));
            @(negedge clk);
            chk("done_pulse", 64'(bif.Msg_Done), 64'(0));
            fin = 1'b1;
          end
        end
      end
    end
    chk("nblocks", 64'(k), abort ? 64'(1) : 64'(nblk));
  endtask

  task automatic run(input logic [7:0] m[$], input bit gaps, input bit abort);
    logic [7:0] e[$];
    model(m, e);
    fork
      drive(m, gaps);
      respond(e, abort);
    join
  endtask

  logic [7:0] msg[$];
  int lens[8] = '{1, 57, 63, 65, 119, 120, 128, 200};

  initial begin
    bif.In_Data     = 8'h00;
    bif.In_Valid    = 1'b0;
    bif.In_Last     = 1'b0;
    bif.Block_Ready = 1'b0;

    repeat (2) @(negedge clk);
    chk("reset_ready",  64'(bif.In_Ready), 64'(0));
    chk("reset_enable", 64'(bif.Block_Enable), 64'(0));
    chk("reset_func",   64'(bif.Block_Function), 64'(0));
    chk("reset_busy",   64'(bif.Busy), 64'(0));
    chk("reset_done",   64'(bif.Msg_Done), 64'(0));
    chk("reset_data",   64'(bif.Block_Data == '0), 64'(1));
    rst = 1'b1;
    @(negedge clk);
    chk("idle_ready", 64'(bif.In_Ready), 64'(1));

    msg = '{8'h61, 8'h62, 8'h63};
    run(msg, 1'b0, 1'b0);

    msg.delete();
    repeat (55) msg.push_back(8'h41);
    run(msg, 1'b1, 1'b0);

    msg.delete();
    repeat (56) msg.push_back(8'h41);
    run(msg, 1'b1, 1'b0);

    msg.delete();
    repeat (64) msg.push_back(8'h41);
    run(msg, 1'b0, 1'b0);

    // In_Valid held high across block boundaries
    msg.delete();
    repeat (130) msg.push_back(8'($urandom));
    run(msg, 1'b0, 1'b0);

    // A stray completion pulse while idle must not disturb anything
    @(negedge clk);
    bif.Block_Ready = 1'b1;
    @(negedge clk);
    bif.Block_Ready = 1'b0;
    chk("stray_busy",   64'(bif.Busy), 64'(0));
    chk("stray_enable", 64'(bif.Block_Enable), 64'(0));
    chk("stray_ready",  64'(bif.In_Ready), 64'(1));
    chk("stray_done",   64'(bif.Msg_Done), 64'(0));

    for (int t = 0; t < 12; t++) begin
      int n;
      n = (t < 8) ? lens[t] : int'($urandom_range(1, 200));
      msg.delete();
      repeat (n) msg.push_back(8'($urandom));
      run(msg, 1'($urandom), 1'b0);
    end

    // Reset while waiting on sha_block, then a clean message
    msg = '{8'h61, 8'h62, 8'h63};
    run(msg, 1'b0, 1'b1);
    run(msg, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
